stereolbm_axis_cambm_mul_pipe: RTL and testbench

Parametrised pipelined multiplier / multiply-accumulate unit. It is the successor to the combinational fixed-width multiplier instances used in the stereo LBM datapath (SAD scaling, disparity interpolation).
- Adds a configurable register depth, a valid/ready handshake with full-pipeline backpressure, and a per-beat signed/unsigned select.
- Adds an optional running accumulation.
- Sits between stream stages of the stereolbm_axis_cambm core.

---
 rtl/stereolbm_mul_pkg.sv | 21 ++
 rtl/stereolbm_mul_stage.sv | 39 +++
 rtl/stereolbm_axis_cambm_mul_pipe.sv | 99 +++++++++
 tb/tb_stereolbm_axis_cambm_mul_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stereolbm_mul_pkg.sv
// Shared definitions for the stereo LBM pipelined multiplier / MAC.
package stereolbm_mul_pkg;

  localparam int unsigned MODE_SIGNED_BIT = 0;
  localparam int unsigned MODE_ACC_BIT    = 1;
  localparam int unsigned MODE_W          = 2;

  localparam int unsigned NUM_STAGE_MIN   = 1;
  localparam int unsigned NUM_STAGE_MAX   = 8;

  typedef logic [MODE_W-1:0] mode_t;

  function automatic logic mode_is_signed(input mode_t m);
    return m[MODE_SIGNED_BIT];
  endfunction

  function automatic logic mode_is_acc(input mode_t m);
    return m[MODE_ACC_BIT];
  endfunction

endpackage

// File: rtl/stereolbm_mul_stage.sv
// One pipeline slice: valid + data + mode register with shared advance enable.
module stereolbm_mul_stage
  import stereolbm_mul_pkg::*;
#(
  parameter int unsigned DATA_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  input  mode_t             i_mode,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data,
  output mode_t             o_mode
);

  logic              r_vld;
  logic [DATA_W-1:0] r_data;
  mode_t             r_mode;

  // Bubbles travel with the data, so the valid bit loads unconditionally on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_mode <= '0;
    end else if (i_en) begin
      r_vld  <= i_vld;
      r_data <= i_data;
      r_mode <= i_mode;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_mode = r_mode;

endmodule

// File: rtl/stereolbm_axis_cambm_mul_pipe.sv
// Pipelined signed/unsigned multiplier with optional running accumulation and
// a valid/ready handshake where a stalled output freezes the whole pipe.
module stereolbm_axis_cambm_mul_pipe
  import stereolbm_mul_pkg::*;
#(
  parameter int          ID         = 1,
  parameter int unsigned NUM_STAGE  = 2,
  parameter int unsigned din0_WIDTH = 6,
  parameter int unsigned din1_WIDTH = 10,
  parameter int unsigned dout_WIDTH = 15
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  mode_t                 in_mode,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout
);

  localparam int unsigned P_W  = din0_WIDTH + din1_WIDTH;
  // Work width covers both the full product and the result, so one multiply
  // gives the correctly extended or truncated value in its low bits.
  localparam int unsigned MW   = (P_W > dout_WIDTH) ? P_W : dout_WIDTH;
  localparam int unsigned LAST = NUM_STAGE - 1;

  if ((NUM_STAGE < NUM_STAGE_MIN) || (NUM_STAGE > NUM_STAGE_MAX) || (ID < 0)) begin : g_bad_param
    $error("stereolbm_axis_cambm_mul_pipe: NUM_STAGE out of range 1..8");
  end

  logic                  w_advance;
  logic                  w_sgn;
  logic [MW-1:0]         w_a_ext;
  logic [MW-1:0]         w_b_ext;
  logic [MW-1:0]         w_prod_full;
  logic [dout_WIDTH-1:0] w_prod_ext;
  logic [dout_WIDTH-1:0] w_sum;

  // Entry k is the input to stage k; the last entry feeds the accumulator stage.
  logic                  w_stg_vld  [NUM_STAGE];
  logic [dout_WIDTH-1:0] w_stg_data [NUM_STAGE];
  mode_t                 w_stg_mode [NUM_STAGE];

  logic                  r_out_vld;
  logic [dout_WIDTH-1:0] r_acc;

  assign w_advance = ~r_out_vld | out_ready;
  assign in_ready  = w_advance;

  assign w_sgn       = mode_is_signed(in_mode);
  assign w_a_ext     = {{(MW-din0_WIDTH){w_sgn & din0[din0_WIDTH-1]}}, din0};
  assign w_b_ext     = {{(MW-din1_WIDTH){w_sgn & din1[din1_WIDTH-1]}}, din1};
  assign w_prod_full = w_a_ext * w_b_ext;
  assign w_prod_ext  = w_prod_full[dout_WIDTH-1:0];

  assign w_stg_vld[0]  = in_valid & w_advance;
  assign w_stg_data[0] = w_prod_ext;
  assign w_stg_mode[0] = in_mode;

  for (genvar k = 0; k < int'(NUM_STAGE) - 1; k++) begin : g_stage
    stereolbm_mul_stage #(
      .DATA_W (dout_WIDTH)
    ) u_stage (
      .clk    (ap_clk),
      .rst_n  (ap_rst_n),
      .i_en   (w_advance),
      .i_vld  (w_stg_vld[k]),
      .i_data (w_stg_data[k]),
      .i_mode (w_stg_mode[k]),
      .o_vld  (w_stg_vld[k+1]),
      .o_data (w_stg_data[k+1]),
      .o_mode (w_stg_mode[k+1])
    );
  end

  assign w_sum = mode_is_acc(w_stg_mode[LAST]) ? (r_acc + w_stg_data[LAST])
                                               : w_stg_data[LAST];

  // Final stage: the accumulator only moves when a valid beat lands here.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_vld <= 1'b0;
      r_acc     <= '0;
    end else if (w_advance) begin
      r_out_vld <= w_stg_vld[LAST];
      if (w_stg_vld[LAST]) begin
        r_acc <= w_sum;
      end
    end
  end

  // The result register and the accumulator always hold the same value.
  assign out_valid = r_out_vld;
  assign dout      = r_acc;

endmodule

// File: tb/tb_stereolbm_axis_cambm_mul_pipe.sv
// Directed bench for the pipelined multiplier: default depth plus depth 1 and 8 sweeps.
module tb_stereolbm_axis_cambm_mul_pipe;

  localparam int NSW = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_mode;
  logic [5:0]  din0;
  logic [9:0]  din1;
  logic [14:0] dout;

  logic        s_valid, s_out_ready;
  logic [1:0]  s_mode;
  logic [5:0]  s_a;
  logic [9:0]  s_b;
  logic        r1_in_ready, r1_out_valid, r8_in_ready, r8_out_valid;
  logic [14:0] r1_dout, r8_dout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stereolbm_axis_cambm_mul_pipe dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .din0(din0), .din1(din1), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout));

  stereolbm_axis_cambm_mul_pipe #(.NUM_STAGE(1)) dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(s_valid), .in_ready(r1_in_ready),
    .in_mode(s_mode), .din0(s_a), .din1(s_b), .out_valid(r1_out_valid),
    .out_ready(s_out_ready), .dout(r1_dout));

  stereolbm_axis_cambm_mul_pipe #(.NUM_STAGE(8)) dut8 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(s_valid), .in_ready(r8_in_ready),
    .in_mode(s_mode), .din0(s_a), .din1(s_b), .out_valid(r8_out_valid),
    .out_ready(s_out_ready), .dout(r8_dout));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [5:0] a, input logic [9:0] b, input logic [1:0] m);
    in_valid = 1'b1;
    din0     = a;
    din1     = b;
    in_mode  = m;
  endtask

  // Single beat into an empty depth-2 pipe: visible after the second edge.
  task automatic send_one(input string tag, input logic [5:0] a, input logic [9:0] b,
                          input logic [1:0] m, input logic [14:0] exp);
    set_beat(a, b, m);
    tick();
    in_valid = 1'b0;
    chk({tag, "_early"}, out_valid, 0);
    tick();
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_dout"}, dout, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  a4 [6];
    logic [9:0]  b4 [6];
    logic [1:0]  m4 [6];
    logic [14:0] e4 [6];
    logic [14:0] e3 [4];
    logic [14:0] held_d;
    logic        held;
    int          sent, rcv, stall_left;
    logic        sv [NSW];
    logic [5:0]  sa [NSW];
    logic [9:0]  sb [NSW];
    logic [1:0]  sm [NSW];
    int          ed [NSW];
    int          acc, pa, pb, e, i8;
    logic        ev;

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'd0; din0 = '0; din1 = '0; out_ready = 1'b1;
    s_valid = 1'b0; s_mode = 2'd0; s_a = '0; s_b = '0; s_out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_in_ready", in_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: unsigned max operands, result truncated to 15 bits.
    send_one("t1", 6'd63, 10'd1023, 2'b00, 15'd31681);
    tick();
    chk("t1_bubble_vld", out_valid, 0);
    chk("t1_bubble_dout", dout, 15'd31681);

    // 2: signed -1 * 2, then the same bits unsigned, back to back.
    set_beat(6'h3F, 10'h002, 2'b01);
    tick();
    set_beat(6'h3F, 10'h002, 2'b00);
    tick();
    in_valid = 1'b0;
    chk("t2_s_vld", out_valid, 1);
    chk("t2_s_dout", dout, 15'h7FFE);
    tick();
    chk("t2_u_vld", out_valid, 1);
    chk("t2_u_dout", dout, 15'd126);
    tick();
    chk("t2_idle", out_valid, 0);

    // 3: accumulate chain on consecutive cycles.
    e3 = '{15'd12, 15'd42, 15'd43, 15'd4};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: set_beat(6'd3, 10'd4, 2'b00);
        1: set_beat(6'd5, 10'd6, 2'b10);
        2: set_beat(6'd1, 10'd1, 2'b10);
        3: set_beat(6'd2, 10'd2, 2'b00);
        default: in_valid = 1'b0;
      endcase
      tick();
      if (i >= 1 && i <= 4) begin
        chk("t3_vld", out_valid, 1);
        chk("t3_dout", dout, e3[i-1]);
      end else if (i == 5) begin
        chk("t3_idle", out_valid, 0);
      end
    end
    in_valid = 1'b0;

    // 4: stream 6 beats with a 5-cycle downstream stall after the first result.
    a4 = '{6'd1, 6'd2, 6'd3, 6'd1, 6'd2, 6'd3};
    b4 = '{10'd1, 10'd1, 10'd1, 10'd2, 10'd2, 10'd3};
    m4 = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10};
    e4 = '{15'd1, 15'd3, 15'd6, 15'd2, 15'd6, 15'd15};
    sent = 0; rcv = 0; stall_left = 5; held = 1'b0; held_d = '0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin
        din0 = a4[sent]; din1 = b4[sent]; in_mode = m4[sent];
      end
      if (rcv >= 1 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (held) begin
        chk("t4_hold_vld", out_valid, 1);
        chk("t4_hold_dout", dout, held_d);
      end
      if (out_valid && !out_ready) chk("t4_in_ready_low", in_ready, 0);
      held   = out_valid && !out_ready;
      held_d = dout;
      if (out_valid && out_ready) begin
        chk("t4_dout", dout, e4[rcv]);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t4_sent", sent, 6);
    chk("t4_rcv", rcv, 6);
    chk("t4_stall_used", stall_left, 0);
    send_one("t4_acc", 6'd1, 10'd1, 2'b10, 15'd16);

    // 5: reset with two beats in flight discards them and clears the accumulator.
    send_one("t5_seed", 6'd6, 10'd7, 2'b00, 15'd42);
    set_beat(6'd1, 10'd1, 2'b10);
    tick();
    set_beat(6'd1, 10'd2, 2'b10);
    tick();
    in_valid = 1'b0;
    chk("t5_pre_vld", out_valid, 1);
    chk("t5_pre_dout", dout, 15'd43);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", out_valid, 0);
    chk("t5_rst_dout", dout, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_stale_vld", out_valid, 0);
    tick();
    chk("t5_no_stale_vld2", out_valid, 0);
    send_one("t5_after", 6'd2, 10'd3, 2'b10, 15'd6);

    // 6: depth 1 and 8 against an integer reference model.
    acc = 0;
    for (int k = 0; k < NSW; k++) begin
      sv[k] = ($urandom_range(0, 3) != 0);
      sa[k] = 6'($urandom);
      sb[k] = 10'($urandom);
      sm[k] = 2'($urandom);
      if (k == 0) begin sv[k] = 1'b1; sa[k] = 6'h20; sb[k] = 10'h200; sm[k] = 2'b11; end
      if (k == 1) begin sv[k] = 1'b1; sa[k] = 6'h3F; sb[k] = 10'h3FF; sm[k] = 2'b00; end
      ed[k] = 0;
      if (sv[k]) begin
        pa = sm[k][0] ? int'($signed(sa[k])) : int'(sa[k]);
        pb = sm[k][0] ? int'($signed(sb[k])) : int'(sb[k]);
        e  = sm[k][1] ? ((acc + pa * pb) & 32'h7FFF) : ((pa * pb) & 32'h7FFF);
        acc   = e;
        ed[k] = e;
      end
    end
    for (int c = 0; c < NSW + 8; c++) begin
      if (c < NSW) begin
        s_valid = sv[c]; s_a = sa[c]; s_b = sb[c]; s_mode = sm[c];
      end else begin
        s_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      ev = (c < NSW) ? sv[c] : 1'b0;
      chk("sw1_vld", r1_out_valid, ev);
      if (ev) chk("sw1_dout", r1_dout, ed[c]);
      chk("sw1_in_ready", r1_in_ready, 1);
      i8 = c - 7;
      ev = (i8 >= 0 && i8 < NSW) ? sv[i8] : 1'b0;
      chk("sw8_vld", r8_out_valid, ev);
      if (ev) chk("sw8_dout", r8_dout, ed[i8]);
      chk("sw8_in_ready", r8_in_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
